// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types for the packet arbiter: FSM encoding and stream byte width.
package axis_packet_arbiter_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bundle of the N upstream byte streams and the single merged downstream stream.
// slave is the arbiter's view; master is the view of the producers/consumer around it.
interface axis_packet_arbiter_if #(
   parameter int N = 4
);
   import axis_packet_arbiter_pkg::*;

   localparam int IDW = $clog2(N);

   logic [BYTE_W*N-1:0] i_tdata;
   logic [N-1:0]        i_tlast;
   logic [N-1:0]        i_tvalid;
   logic [N-1:0]        o_tready;
   logic [BYTE_W-1:0]   o_tdata;
   logic                o_tlast;
   logic                o_tvalid;
   logic                i_tready;
   logic [IDW-1:0]      o_tid;

   modport slave (
      input  i_tdata, i_tlast, i_tvalid, i_tready,
      output o_tready, o_tdata, o_tlast, o_tvalid, o_tid
   );

   modport master (
      output i_tdata, i_tlast, i_tvalid, i_tready,
      input  o_tready, o_tdata, o_tlast, o_tvalid, o_tid
   );

endinterface

// File: rtl/axis_packet_arbiter_rr_pick.sv
// rr_pick: combinational circular priority encoder. Searches the request
// vector starting one past `last` and wrapping at N-1, so any N in 2..16 works.
module axis_packet_arbiter_rr_pick #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [IDW-1:0] idx,
   output logic           any
);

   localparam logic [IDW-1:0] IDX_MAX = IDW'(N - 1);

   // Walk the ring last+1 .. last; the first requester encountered wins.
   always_comb begin
      logic [IDW-1:0] cand;
      // NOTE: every output and temporary gets a value before any branch, so no path leaves a stale value and no latch is inferred.
      idx  = '0;
      any  = 1'b0;
      cand = last;
      for (int i = 0; i < N; i++) begin
         cand = (cand == IDX_MAX) ? '0 : cand + IDW'(1);
         if (!any && req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular AXI-Stream arbiter. A source keeps the grant
// from its first byte through the handshake of its tlast byte, so packets
// never interleave on the merged output.
module axis_packet_arbiter #(
   parameter int N = 4
) (
   input logic                  i_clk,
   input logic                  i_rst,
   axis_packet_arbiter_if.slave bus
);
   import axis_packet_arbiter_pkg::*;

   localparam int             IDW     = $clog2(N);
   localparam logic [IDW-1:0] IDX_MAX = IDW'(N - 1);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] grant_nxt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] last_nxt;
   logic [IDW-1:0] pick_idx;
   logic           pick_any;

   axis_packet_arbiter_rr_pick #(
      .N (N)
   ) u_rr_pick (
      .req  (bus.i_tvalid),
      .last (last),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // State and arbitration registers; reset makes source 0 the first choice.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      if (i_rst) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= IDX_MAX;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

   // Next-state logic and the output mux from the granted source.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      last_nxt     = last;
      bus.o_tdata  = '0;
      bus.o_tlast  = 1'b0;
      bus.o_tvalid = 1'b0;
      bus.o_tready = '0;
      bus.o_tid    = '0;
      case (state)
         ST_IDLE: begin
            // Outputs stay quiet for the arbitration cycle.
            if (pick_any) begin
               grant_nxt = pick_idx;
               last_nxt  = pick_idx;
               state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            bus.o_tdata         = bus.i_tdata[BYTE_W*int'(grant) +: BYTE_W];
            bus.o_tlast         = bus.i_tlast[grant];
            bus.o_tvalid        = bus.i_tvalid[grant];
            bus.o_tready[grant] = bus.i_tready;
            bus.o_tid           = grant;
            // Only the tlast handshake releases the grant; a valid gap just waits.
            if (bus.i_tvalid[grant] && bus.i_tready && bus.i_tlast[grant]) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin, packet-granular AXI-Stream arbiter merging byte streams from N producer cores onto the single 8-bit stream consumed by the `emitter` (`i_tdata`/`i_tlast`/`i_tvalid`/`o_tready`). A grant is held from a packet's first byte through the handshake of its `tlast` byte, so packets never interleave on the `emitter` input. It also reports which source owns the current packet.

## Interface
- `N`, 4: number of upstream sources; legal range 2..16.
- `IDW`, `$clog2(N)`: width of `o_tid`; derived, never overridden.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_tdata`  in  8*N  source data; source k occupies bits [8k+7:8k].
- `i_tlast`  in  N  per-source last-byte-of-packet flag.
- `i_tvalid`  in  N  per-source valid.
- `o_tready`  out  N  per-source ready.
- `o_tdata`  out  8  merged data to `emitter`.
- `o_tlast`  out  1  merged last flag.
- `o_tvalid`  out  1  merged valid.
- `i_tready`  in  1  ready from `emitter`.
- `o_tid`  out  IDW  index of the granted source; valid while `o_tvalid`=1.

## Operation
- Two states, IDLE and LOCKED. Registers: `state`, `grant` (IDW bits), `last` (IDW bits, last granted index).
- IDLE: all `o_tready`=0, `o_tvalid`=0. If any `i_tvalid` bit is set, choose the first set bit in circular order `last+1, last+2, …, last` (mod N). Load `grant` and `last` with that index and go to LOCKED. If no bit is set, stay in IDLE.
- LOCKED, outputs:
  - `o_tdata` = slice `grant` of `i_tdata`.
  - `o_tlast` = `i_tlast[grant]`.
  - `o_tvalid` = `i_tvalid[grant]`.
  - `o_tready[grant]` = `i_tready`; all other `o_tready` bits = 0.
  - `o_tid` = `grant`.
- LOCKED, transitions:
  - A transfer occurs when `o_tvalid & i_tready`.
  - A transfer with `o_tlast`=1 returns to IDLE.
  - `i_tvalid[grant]` dropping mid-packet does not release the grant; wait indefinitely.
- Valid bits on non-granted sources are ignored while LOCKED. Those sources see `o_tready`=0 and must hold their data (AXI-S rule).
- Index wrap: `last+1` wraps from N-1 to 0. Arithmetic is done in IDW bits with an explicit compare against N-1, so non-power-of-two N works.
- Reset:
  - `state`=IDLE, `grant`=0, `last`=N-1, so source 0 has first priority after reset.
  - Reset mid-packet abandons the packet. The remaining bytes of that packet are treated as a new packet on the next grant; the producers are reset alongside.

## Timing
- Reset values of all outputs: `o_tvalid`=0, `o_tready`=0, `o_tdata`=0, `o_tlast`=0, `o_tid`=0.
- Arbitration latency: 1 cycle. `i_tvalid[k]` rising in cycle t while IDLE gives `o_tvalid` no earlier than t+1.
- Data path is combinational from the granted source to the output; no added byte latency once LOCKED. One byte per cycle is sustained when `i_tready`=1.
- Inter-packet gap: exactly 1 IDLE cycle after each `tlast` transfer. A back-to-back request from any source is granted in that cycle and streams from the next cycle.
- Simultaneous requests: resolved purely by round-robin order from `last`.
- Single-byte packet (`tlast` on the first byte): LOCKED for one transfer cycle, then IDLE.
- `i_tready`=0 with `o_tvalid`=1: all outputs hold and the state is unchanged.

## Structure
- No shared package entries needed. IDW is derived locally.
- One natural sub-module: `rr_pick`, a combinational circular priority encoder.
  - Inputs: N-bit request vector and IDW-bit `last`.
  - Outputs: IDW-bit index and an `any` flag.
  - Reusable by other corescore arbiters.
- Top-level holds the FSM, `grant`/`last` registers and the output mux.

## Test plan
- Reset, then `i_tvalid`=4'b1111 with each source sending a 2-byte packet (source k: 0x10+k, 0x20+k with tlast) and `i_tready`=1 → `o_tid` sequence 0,1,2,3. Output bytes 10,20,11,21,12,22,13,23, with one idle cycle between packets.
- Source 2 sends a 5-byte packet while source 1 asserts valid from its second byte → all 5 bytes of source 2 appear contiguously before any source 1 byte, and `o_tready[1]`=0 throughout.
- `i_tready` toggling 1,0,0,1 during a packet → `o_tdata`, `o_tlast` and `o_tid` stable while stalled, and no byte duplicated or lost.
- Granted source drops `i_tvalid` for 3 cycles mid-packet while source 3 is valid → the grant is retained and source 3 waits until the first source's tlast transfer.
- Wrap: `last`=3 (N=4), requests 4'b1001 → grant 0; then requests 4'b1000 → grant 3.
- Assert `i_rst` for 1 cycle mid-packet of source 1 → next cycle `o_tvalid`=0 and all `o_tready`=0. With all sources requesting afterwards, the first grant is 0.
